// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin lock arbiter.
package rr_arb_pkg;

    // Default bound on consecutive locked cycles before a forced release.
    localparam int LockMaxDefault = 16;

    // Increment an index and wrap at n explicitly, so non-power-of-two
    // requester counts never rely on natural overflow.
    function automatic int next_idx_wrap(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared port.
interface rr_lock_arbiter_if #(
    parameter int NumIn = 4
);
    localparam int IdxW = $clog2(NumIn);

    logic             flush_i;
    logic [NumIn-1:0] req_i;
    logic             lock_i;
    logic             ready_i;
    logic             valid_o;
    logic [IdxW-1:0]  idx_o;
    logic [NumIn-1:0] gnt_o;
    logic             locked_o;
    logic             lock_timeout_o;

    // Requester / downstream side: drives requests and ready, observes selection.
    modport master (
        output flush_i, req_i, lock_i, ready_i,
        input  valid_o, idx_o, gnt_o, locked_o, lock_timeout_o
    );

    // Arbiter side.
    modport slave (
        input  flush_i, req_i, lock_i, ready_i,
        output valid_o, idx_o, gnt_o, locked_o, lock_timeout_o
    );
endinterface

// File: rtl/rr_prio_pick.sv
// Combinational round-robin find-first: first set request at or after ptr_i.
module rr_prio_pick #(
    parameter int NumIn = 4,
    parameter int IdxW  = $clog2(NumIn)
) (
    input  logic [NumIn-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);
    int              cand;
    logic [IdxW-1:0] cand_idx;

    // Scan from the farthest candidate back to ptr_i so the nearest one wins last.
    always_comb begin
        idx_o    = ptr_i;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NumIn - 1; k >= 0; k--) begin
            cand = int'(ptr_i) + k;
            if (cand >= NumIn) begin
                cand = cand - NumIn;
            end
            cand_idx = IdxW'(cand);
            if (req_i[cand_idx]) begin
                idx_o   = cand_idx;
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant lock, handshake stability and bounded lock time.
module rr_lock_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NumIn   = 4,
    parameter int IdxW    = $clog2(NumIn),
    parameter int LockMax = LockMaxDefault,
    parameter int CntW    = $clog2(LockMax + 1)
) (
    input logic              clk_i,
    input logic              rst_ni,
    rr_lock_arbiter_if.slave bus
);
    typedef struct packed {
        logic [IdxW-1:0] ptr;
        logic            lock;
        logic [IdxW-1:0] lock_idx;
        logic [CntW-1:0] cnt;
    } arb_state_t;

    arb_state_t      st_q, st_d;
    logic [IdxW-1:0] rr_idx, sel_idx;
    logic            rr_valid, sel_valid, lock_hit, hs, at_limit, timeout, hold;

    rr_prio_pick #(.NumIn(NumIn), .IdxW(IdxW)) u_pick (
        .req_i  (bus.req_i),
        .ptr_i  (st_q.ptr),
        .idx_o  (rr_idx),
        .valid_o(rr_valid)
    );

    // A lock only takes effect while its owner is still requesting.
    assign lock_hit  = st_q.lock && bus.req_i[st_q.lock_idx];
    assign sel_valid = lock_hit || rr_valid;
    assign sel_idx   = lock_hit ? st_q.lock_idx : rr_idx;
    assign hs        = sel_valid && bus.ready_i;
    assign at_limit  = st_q.cnt >= CntW'(LockMax - 1);
    // Forced release only when lock_i is the sole reason to hold (beat accepted).
    assign timeout   = lock_hit && bus.lock_i && bus.ready_i && at_limit;

    assign bus.valid_o        = sel_valid;
    assign bus.idx_o          = sel_idx;
    assign bus.locked_o       = st_q.lock;
    assign bus.lock_timeout_o = timeout && !bus.flush_i;

    // One-hot grant on the accepted beat.
    always_comb begin
        bus.gnt_o = '0;
        if (hs) begin
            bus.gnt_o[sel_idx] = 1'b1;
        end
    end

    // Lock / pointer / timer next-state; flush overrides everything.
    always_comb begin
        st_d = st_q;
        hold = 1'b0;
        if (lock_hit || !st_q.lock) begin
            hold = sel_valid && (bus.lock_i || !bus.ready_i);
        end else begin
            // Owner dropped: keep only an un-acked beat stable, never re-lock it.
            hold = sel_valid && !bus.ready_i;
        end
        if (timeout) begin
            hold = 1'b0;
        end
        st_d.lock = hold;
        if (hold) begin
            st_d.lock_idx = sel_idx;
            if (st_q.lock) begin
                st_d.cnt = (st_q.cnt < CntW'(LockMax)) ? st_q.cnt + 1'b1 : st_q.cnt;
            end else begin
                st_d.cnt = '0;
            end
        end else begin
            st_d.cnt = '0;
        end
        if (hs && !hold) begin
            st_d.ptr = IdxW'(next_idx_wrap(int'(sel_idx), NumIn));
        end
        if (bus.flush_i) begin
            st_d = '0;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.gnt_o));

    a_idx_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.valid_o && !bus.ready_i && !bus.flush_i && bus.req_i[bus.idx_o])
        |=> (bus.idx_o == $past(bus.idx_o)));

    a_unlocked_after_reset: assert property (@(posedge clk_i)
        $rose(rst_ni) |-> !bus.locked_o);
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (NumIn=4, LockMax=16).
module tb_rr_lock_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    rr_lock_arbiter_if #(.NumIn(4)) bus ();

    rr_lock_arbiter #(.NumIn(4), .LockMax(16)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Inputs change 2 units after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus.req_i   = 4'b0000;
        bus.lock_i  = 1'b0;
        bus.ready_i = 1'b1;
        bus.flush_i = 1'b0;

        // Reset values
        #3;
        chk("rst_valid", int'(bus.valid_o), 0);
        chk("rst_idx", int'(bus.idx_o), 0);
        chk("rst_gnt", int'(bus.gnt_o), 0);
        chk("rst_locked", int'(bus.locked_o), 0);
        chk("rst_tmo", int'(bus.lock_timeout_o), 0);
        bus.req_i = 4'b1111;
        #9 rst_n = 1'b1;
        #1;
        chk("rr_idx0", int'(bus.idx_o), 0);
        chk("rr_gnt0", int'(bus.gnt_o), 1);
        for (int i = 1; i < 5; i++) begin
            step();
            #1;
            chk("rr_idx", int'(bus.idx_o), i % 4);
            chk("rr_gnt", int'(bus.gnt_o), 1 << (i % 4));
            if (i == 1) chk("rr_locked_first", int'(bus.locked_o), 0);
        end

        // Flush clears the pointer (currently 1)
        step(); bus.req_i = 4'b0000; bus.flush_i = 1'b1; #1;
        chk("fl_valid", int'(bus.valid_o), 0);
        chk("fl_idx_before", int'(bus.idx_o), 1);

        // Locked transfer: requester 1 holds for 3 lock cycles plus the release beat
        step(); bus.flush_i = 1'b0; bus.req_i = 4'b0110; bus.lock_i = 1'b1; #1;
        chk("lk_idx_a", int'(bus.idx_o), 1);
        chk("lk_gnt_a", int'(bus.gnt_o), 2);
        chk("lk_locked_a", int'(bus.locked_o), 0);
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            chk("lk_idx_bc", int'(bus.idx_o), 1);
            chk("lk_gnt_bc", int'(bus.gnt_o), 2);
            chk("lk_locked_bc", int'(bus.locked_o), 1);
        end
        step(); bus.lock_i = 1'b0; #1;
        chk("lk_idx_d", int'(bus.idx_o), 1);
        chk("lk_gnt_d", int'(bus.gnt_o), 2);
        step(); #1;
        chk("lk_idx_e", int'(bus.idx_o), 2);
        chk("lk_gnt_e", int'(bus.gnt_o), 4);
        chk("lk_locked_e", int'(bus.locked_o), 0);

        // Backpressure stability
        step(); bus.req_i = 4'b0000; bus.flush_i = 1'b1; #1;
        step(); bus.flush_i = 1'b0; bus.req_i = 4'b1001; bus.ready_i = 1'b0; #1;
        chk("bp_idx0", int'(bus.idx_o), 0);
        chk("bp_gnt0", int'(bus.gnt_o), 0);
        for (int i = 1; i < 5; i++) begin
            step(); #1;
            chk("bp_idx", int'(bus.idx_o), 0);
            chk("bp_gnt", int'(bus.gnt_o), 0);
        end
        step(); bus.ready_i = 1'b1; #1;
        chk("bp_idx_rdy", int'(bus.idx_o), 0);
        chk("bp_gnt_rdy", int'(bus.gnt_o), 1);
        step(); #1;
        chk("bp_idx_next", int'(bus.idx_o), 3);
        chk("bp_gnt_next", int'(bus.gnt_o), 8);

        // Timeout: pulse in the 16th locked cycle, then requester 1
        step(); bus.req_i = 4'b0011; bus.lock_i = 1'b1; #1;
        chk("to_idx_acq", int'(bus.idx_o), 0);
        chk("to_locked_acq", int'(bus.locked_o), 0);
        for (int k = 1; k <= 16; k++) begin
            step(); #1;
            chk("to_idx", int'(bus.idx_o), 0);
            chk("to_pulse", int'(bus.lock_timeout_o), (k == 16) ? 1 : 0);
        end
        step(); #1;
        chk("to_idx_after", int'(bus.idx_o), 1);
        chk("to_pulse_after", int'(bus.lock_timeout_o), 0);
        chk("to_locked_after", int'(bus.locked_o), 0);

        // Timeout coinciding with flush: no pulse, state cleared
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 16) bus.flush_i = 1'b1;
            #1;
            chk("tf_idx", int'(bus.idx_o), 1);
            if (k == 16) chk("tf_pulse", int'(bus.lock_timeout_o), 0);
        end
        step(); bus.flush_i = 1'b0; #1;
        chk("tf_locked", int'(bus.locked_o), 0);
        chk("tf_idx_after", int'(bus.idx_o), 0);

        // Locked requester drops its request
        step(); bus.req_i = 4'b0000; bus.lock_i = 1'b0; bus.flush_i = 1'b1; #1;
        step(); bus.flush_i = 1'b0; bus.req_i = 4'b0100; bus.lock_i = 1'b1; #1;
        chk("dr_idx_acq", int'(bus.idx_o), 2);
        step(); #1;
        chk("dr_locked", int'(bus.locked_o), 1);
        step(); bus.req_i = 4'b1000; bus.lock_i = 1'b0; #1;
        chk("dr_idx_drop", int'(bus.idx_o), 3);
        chk("dr_gnt_drop", int'(bus.gnt_o), 8);
        step(); #1;
        chk("dr_locked_next", int'(bus.locked_o), 0);

        // Asynchronous reset while locked on requester 3
        step(); bus.req_i = 4'b0010; #1;
        chk("ar_idx_pre", int'(bus.idx_o), 1);
        step(); bus.req_i = 4'b1000; bus.lock_i = 1'b1; #1;
        chk("ar_idx_acq", int'(bus.idx_o), 3);
        step(); #1;
        chk("ar_locked", int'(bus.locked_o), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_locked_rst", int'(bus.locked_o), 0);
        rst_n = 1'b1;
        bus.req_i  = 4'b1111;
        bus.lock_i = 1'b0;
        #1;
        chk("ar_idx_post", int'(bus.idx_o), 0);
        step(); #1;
        chk("ar_idx_post2", int'(bus.idx_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Shares one downstream resource port between NumIn requesters using round-robin priority.
- The winning requester may hold the grant across a multi-beat transfer via `lock_i`. A bounded lock timer forces release so that no requester can starve the others.
- Sits between master-side request ports and a single shared slave or datapath port. It generates the selection index that drives the data mux.

Parameters:
- NumIn, 4, number of requesters (≥2)
- IdxW, $clog2(NumIn), width of the selection index (derived; do not override)
- LockMax, 16, maximum consecutive cycles a lock may be held before forced release (≥2)
- CntW, $clog2(LockMax+1), lock counter width (derived)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of lock, pointer and counter
- req_i  in  NumIn  per-requester request
- lock_i  in  1  current winner requests that the grant be held after this cycle
- ready_i  in  1  downstream accepts the beat this cycle
- valid_o  out  1  some requester is selected
- idx_o  out  IdxW  selected requester index
- gnt_o  out  NumIn  one-hot handshake grant: `valid_o & ready_i & (idx_o==i)`
- locked_o  out  1  selection is currently frozen (reflects lock_q)
- lock_timeout_o  out  1  one-cycle pulse when a forced release occurs

Behaviour:
- State:
  - ptr_q (IdxW): highest-priority index
  - lock_q: selection frozen
  - lock_idx_q (IdxW): frozen index
  - cnt_q (CntW): cycles lock held
- Reset (async, rst_ni=0) clears all state: ptr_q=0, lock_q=0 (unlocked), lock_idx_q=0, cnt_q=0.
  - Outputs during and after reset with req_i=0: valid_o=0, idx_o=0, gnt_o=0, locked_o=0, lock_timeout_o=0.
  - Reset mid-transfer drops the lock immediately; no grant persists.
- Unlocked selection (combinational, zero latency):
  - idx_o = first i with req_i[i]=1, scanning ptr_q, ptr_q+1, … wrapping modulo NumIn.
  - valid_o = |req_i. If req_i=0, idx_o=ptr_q.
- Locked selection: if lock_q and req_i[lock_idx_q]=1, then idx_o=lock_idx_q and valid_o=1, regardless of other requests.
  - If the locked requester drops req, the lock is ignored that cycle: unlocked selection applies and lock_q clears next edge.
- Lock next-state (lock_d) is set when valid_o & ((lock_i) | (~ready_i)), i.e. held for an explicit lock or for a pending handshake (stability rule).
  - When lock_d=1, lock_idx_q <= idx_o.
  - Otherwise lock_q <= 0.
- Stability rule: once valid_o=1 with ready_i=0, idx_o must not change until the handshake completes. This applies even through a timeout; timeout never overrides a pending un-acked beat.
- Pointer: on a handshake (valid_o & ready_i) with lock_d=0, ptr_q <= (idx_o+1) mod NumIn. Otherwise ptr_q holds.
- Timeout counter:
  - cnt_q increments each cycle lock_q=1 and lock_d=1; it clears whenever lock_d=0.
  - When cnt_q==LockMax-1 and lock_i is the only reason to hold (ready_i=1), the lock is forced released:
    - lock_q <= 0, cnt_q <= 0
    - ptr_q <= (idx_o+1) mod NumIn
    - lock_timeout_o=1 that cycle (combinational pulse)
  - The same requester re-acquires only after round-robin reaches it again.
- flush_i: same effect as reset on state, at the next edge. It has priority over all other updates. Outputs in the flush cycle follow normal combinational rules.
- Simultaneous events:
  - Handshake plus lock_i=1: lock holds and the pointer does not advance.
  - Timeout plus flush: flush wins, no timeout pulse.
- Widths: pointer arithmetic wraps explicitly at NumIn when NumIn is not a power of two; never rely on natural overflow.
- Assertions:
  - gnt_o is onehot0.
  - idx_o stable while valid_o & ~ready_i.
  - locked_o=0 in the first cycle after reset.

Decomposition:
- Shared package `rr_arb_pkg`:
  - arbiter state struct {ptr, lock, lock_idx, cnt}
  - function `next_idx_wrap(idx, n)`
  - default LockMax constant
- One sub-module `rr_prio_pick`: combinational masked round-robin find-first. Inputs are req and ptr; outputs are idx and valid.
- Timer and lock FSM stay in the top level.

Test Plan:
- Reset value:
  - Stimulus: hold rst_ni=0 with req_i=4'b1111, then release, ready_i=1.
  - Required response: locked_o=0 on the first edge; idx_o sequence is 0,1,2,3,0 with one gnt_o bit per cycle.
- Locked transfer:
  - Stimulus: req_i=4'b0110, ptr=0, lock_i=1 for 3 cycles, ready_i=1.
  - Required response: idx_o=1 for 4 cycles, then 2. Requester 2 gets no grant while locked.
- Backpressure stability:
  - Stimulus: req_i=4'b1001, ready_i=0 for 5 cycles, lock_i=0.
  - Required response: idx_o=0 stable throughout. Grant occurs on the ready cycle; next idx_o=3.
- Timeout:
  - Stimulus: LockMax=16, req_i=4'b0011, lock_i held high, ready_i=1.
  - Required response: lock_timeout_o pulses in cycle 16; idx_o=1 in cycle 17.
- Locked requester drops:
  - Stimulus: lock on idx 2, then req_i changes 4'b0100→4'b1000.
  - Required response: idx_o=3 in the same cycle; locked_o=0 next cycle.
- Async reset mid-lock:
  - Stimulus: rst_ni pulsed low between edges while locked on idx 3.
  - Required response: locked_o=0 immediately; next selection starts from ptr=0.
